mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 4-input, 32-bit datapath mux between four requesters.
//   Each requester owns the mux until it drops req, or until a hold limit forces it to release.
//   Drives the mux 2-bit select (sel), a one-hot grant and status flags.
//   Sits between the requesting units and the Mux4x1 ctrl input in the 32-bit processor.
// PARAMETERS
//   MAX_HOLD  16  max consecutive cycles one owner keeps the grant; 0 = unlimited (no timeout)
//   CNT_W     5   hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous, active-high reset
//   req      in   4  level request, bit i = requester i (mux input A,B,C,D = 0..3)
//   gnt      out  4  registered one-hot grant; all-zero when idle
//   sel      out  2  registered mux select = index of current/last owner
//   busy     out  1  1 while any gnt bit is set
//   timeout  out  1  one-cycle pulse on the edge where an owner is forcibly released
// BEHAVIOUR
//   - Reset (async, immediate):
//     - outputs: gnt=0, sel=0, busy=0, timeout=0.
//     - internal: state=IDLE, last=3 (req0 wins first), hold_cnt=0, excl=0.
//   - States: IDLE (no owner), OWN (one owner, gnt one-hot).
//   - Arbitration, combinational:
//     - Scan last+1, last+2, last+3, last (mod 4); pick the first requester with req set
//       and not excluded.
//     - Winner is registered: gnt, sel and last all update on the same edge.
//     - hold_cnt clears to 0 on every new grant.
//   - IDLE:
//     - Any eligible req -> grant on the next edge (1-cycle req->gnt latency); go to OWN.
//     - No eligible req -> stay IDLE; gnt=0; sel holds the last owner so the mux output
//       stays stable.
//     - excl clears after one IDLE cycle.
//   - OWN:
//     - While owner req=1 and no timeout: hold_cnt++, all outputs stable.
//     - Release: owner req=0 -> arbitrate among the other requesters in the same cycle.
//       - Winner found -> handover on the next edge with no idle bubble; stay in OWN.
//       - No winner -> gnt=0, go to IDLE.
//     - Timeout: MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 while req still 1.
//       - Owner is granted exactly MAX_HOLD cycles.
//       - Pulse timeout; arbitrate with the owner excluded (excl = owner) for that one decision.
//       - Only the owner requesting -> gnt=0 for one IDLE cycle, then the owner is re-granted.
//     - Requests from non-owners never preempt the owner.
//   - Simultaneous events:
//     - Release and timeout on the same edge -> treat as a release; no timeout pulse.
//     - A new req arriving on the release edge is eligible in that arbitration.
//   - Invariants:
//     - gnt is always one-hot or zero.
//     - sel == encode(gnt) whenever busy=1.
//     - busy == |gnt.
//   - Reset mid-grant: gnt drops asynchronously; after deassert, arbitration restarts from
//     last=3.
// TESTING
//   1. Reset, req=4'b0001 -> gnt=0001, sel=0, busy=1 one cycle after req; req=0 -> next edge
//      gnt=0, busy=0, sel stays 0.
//   2. req=4'b1111 held, each owner drops req after 2 cycles -> grant order 0,1,2,3,0,
//      no idle cycles between owners.
//   3. MAX_HOLD=16, req=4'b0100 held -> gnt=0100 for exactly 16 cycles, then timeout=1,
//      gnt=0 for 1 cycle, then re-granted.
//   4. Owner 2 held to timeout with req=4'b0110 -> timeout pulse, gnt=0010 next edge, sel=1.
//   5. Owner 1 releases on the same edge its hold_cnt hits 15 -> timeout stays 0, normal handover.
//   6. rst asserted mid-grant (gnt=1000) -> gnt=0, sel=0 without a clock edge;
//      after release, req=4'b1001 -> gnt=0001.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the mux4 round-robin arbiter.
// master = arbiter side, slave = requester side.
interface mux4_rr_arbiter_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       timeout;

   modport master (
      input  req,
      output gnt,
      output sel,
      output busy,
      output timeout
   );

   modport slave (
      output req,
      input  gnt,
      input  sel,
      input  busy,
      input  timeout
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 x 32-bit mux; an owner keeps the grant until it
// drops req or is forced off after MAX_HOLD consecutive cycles (0 = no limit).
module mux4_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   mux4_rr_arbiter_if.master     bus
);

   typedef enum logic [0:0] {StIdle, StOwn} state_e;

   state_e             state_q, state_d;
   logic [3:0]         gnt_q, gnt_d;
   logic [1:0]         sel_q, sel_d;
   logic [1:0]         last_q, last_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic               timeout_q, timeout_d;

   logic [3:0]         excl;
   logic [3:0]         elig;
   logic               owner_req;
   logic               hold_expired;
   logic               found;
   logic [1:0]         win;

   assign owner_req    = bus.req[last_q];
   assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

   // The owner is masked out only for the decision made on its forced release.
   always_comb begin
      excl = 4'b0000;
      if (state_q == StOwn && owner_req && hold_expired) begin
         excl = gnt_q;
      end
   end

   assign elig = bus.req & ~excl;

   // Priority scan last+1, last+2, last+3, last (mod 4).
   always_comb begin
      logic [1:0] idx;
      found = 1'b0;
      win   = last_q;
      for (int i = 1; i <= 4; i++) begin
         idx = last_q + 2'(i);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      sel_d      = sel_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d    = StOwn;
               gnt_d      = 4'b0001 << win;
               sel_d      = win;
               last_d     = win;
               hold_cnt_d = '0;
            end
         end
         StOwn: begin
            if (owner_req && !hold_expired) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end else begin
               // Release wins over timeout when both land on the same edge.
               timeout_d = owner_req;
               if (found) begin
                  gnt_d      = 4'b0001 << win;
                  sel_d      = win;
                  last_d     = win;
                  hold_cnt_d = '0;
               end else begin
                  state_d = StIdle;
                  gnt_d   = 4'b0000;
               end
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         gnt_q      <= 4'b0000;
         sel_q      <= 2'd0;
         last_q     <= 2'd3;
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         sel_q      <= sel_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.sel     = sel_q;
   assign bus.busy    = |gnt_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, rotation, hold-limit timeout, same-edge release
// and asynchronous reset mid-grant.
module tb_mux4_rr_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   mux4_rr_arbiter_if bus_if ();

   mux4_rr_arbiter #(
      .MAX_HOLD (16),
      .CNT_W    (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus_if.req = 4'b0000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      bus_if.req = 4'b0000;
      #3;
      chk("reset_gnt", {28'd0, bus_if.gnt}, 32'h0);
      chk("reset_sel", {30'd0, bus_if.sel}, 32'h0);
      chk("reset_busy", {31'd0, bus_if.busy}, 32'h0);
      chk("reset_timeout", {31'd0, bus_if.timeout}, 32'h0);

      // 1: single requester, grant latency and idle return
      do_reset();
      bus_if.req = 4'b0001;
      tick();
      chk("t1_gnt", {28'd0, bus_if.gnt}, 32'h1);
      chk("t1_sel", {30'd0, bus_if.sel}, 32'h0);
      chk("t1_busy", {31'd0, bus_if.busy}, 32'h1);
      bus_if.req = 4'b0000;
      tick();
      chk("t1_idle_gnt", {28'd0, bus_if.gnt}, 32'h0);
      chk("t1_idle_busy", {31'd0, bus_if.busy}, 32'h0);
      chk("t1_idle_sel", {30'd0, bus_if.sel}, 32'h0);

      // 2: all requesting, each owner releases after 2 cycles -> 0,1,2,3,0 with no bubble
      do_reset();
      bus_if.req = 4'b1111;
      tick();
      chk("t2_first", {28'd0, bus_if.gnt}, 32'h1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t2_hold", {28'd0, bus_if.gnt}, 32'(4'b0001 << k));
         bus_if.req = 4'b1111 & ~(4'b0001 << k);
         tick();
         chk("t2_handover_gnt", {28'd0, bus_if.gnt}, 32'(4'b0001 << ((k + 1) % 4)));
         chk("t2_handover_sel", {30'd0, bus_if.sel}, 32'((k + 1) % 4));
         chk("t2_no_bubble", {31'd0, bus_if.busy}, 32'h1);
         bus_if.req = 4'b1111;
      end

      // 3: lone requester held past the limit
      do_reset();
      bus_if.req = 4'b0100;
      tick();
      chk("t3_grant", {28'd0, bus_if.gnt}, 32'h4);
      for (int c = 1; c < 16; c++) begin
         tick();
         chk("t3_held", {28'd0, bus_if.gnt}, 32'h4);
         chk("t3_no_to", {31'd0, bus_if.timeout}, 32'h0);
      end
      tick();
      chk("t3_timeout", {31'd0, bus_if.timeout}, 32'h1);
      chk("t3_gap_gnt", {28'd0, bus_if.gnt}, 32'h0);
      chk("t3_gap_sel", {30'd0, bus_if.sel}, 32'h2);
      tick();
      chk("t3_regrant", {28'd0, bus_if.gnt}, 32'h4);
      chk("t3_to_clear", {31'd0, bus_if.timeout}, 32'h0);

      // 4: timeout hands over to the waiting requester 1
      do_reset();
      bus_if.req = 4'b0100;
      tick();
      bus_if.req = 4'b0110;
      for (int c = 1; c < 16; c++) begin
         tick();
      end
      chk("t4_no_preempt", {28'd0, bus_if.gnt}, 32'h4);
      tick();
      chk("t4_timeout", {31'd0, bus_if.timeout}, 32'h1);
      chk("t4_gnt", {28'd0, bus_if.gnt}, 32'h2);
      chk("t4_sel", {30'd0, bus_if.sel}, 32'h1);

      // 5: owner releases on the same edge its hold limit would fire
      do_reset();
      bus_if.req = 4'b0010;
      tick();
      for (int c = 1; c < 16; c++) begin
         tick();
      end
      chk("t5_pre", {28'd0, bus_if.gnt}, 32'h2);
      bus_if.req = 4'b0100;
      tick();
      chk("t5_no_timeout", {31'd0, bus_if.timeout}, 32'h0);
      chk("t5_gnt", {28'd0, bus_if.gnt}, 32'h4);
      chk("t5_sel", {30'd0, bus_if.sel}, 32'h2);

      // 6: asynchronous reset mid-grant, then restart from last=3
      do_reset();
      bus_if.req = 4'b1000;
      tick();
      chk("t6_grant", {28'd0, bus_if.gnt}, 32'h8);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_gnt", {28'd0, bus_if.gnt}, 32'h0);
      chk("t6_async_sel", {30'd0, bus_if.sel}, 32'h0);
      chk("t6_async_busy", {31'd0, bus_if.busy}, 32'h0);
      tick();
      rst = 1'b0;
      bus_if.req = 4'b1001;
      tick();
      chk("t6_restart", {28'd0, bus_if.gnt}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
